// File: rtl/async_counter3_pkg.sv
// Shared constants for the 3-bit synchronous ripple-equivalent counter.
package async_counter3_pkg;

    localparam int unsigned CNT_W = 3;

    localparam logic [CNT_W-1:0] CNT_RST = 3'b000;

endpackage

// File: rtl/async_counter3_if.sv
// Bundles the counter's enable input and count output for bench/system wiring.
interface async_counter3_if;
    import async_counter3_pkg::*;

    logic             T;
    logic [CNT_W-1:0] out;

    // Driver of the enable, consumer of the count.
    modport master (
        output T,
        input  out
    );

    // The counter itself.
    modport slave (
        input  T,
        output out
    );

endinterface

// File: rtl/async_counter3_t_ff.sv
// Single toggle stage: flips when both enable and toggle are high on a rising clk.
module t_ff
    import async_counter3_pkg::*;
#(
    parameter logic RST_VAL = CNT_RST[0]
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic t,
    output logic q
);

    logic q_d;
    logic q_q;

    // Next state: toggle when enabled, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (en && t) begin
            q_d = ~q_q;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // Output straight from the flop.
    always_comb begin
        q = q_q;
    end

endmodule

// File: rtl/async_counter3.sv
// 3-bit up counter built as a chain of toggle stages on one clock; behaves like
// a ripple T-flop counter without derived clocks or between-edge glitches.
module async_counter3
    import async_counter3_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] out,
    input  logic             T
);

    logic [CNT_W-1:0] stage_q;
    logic [CNT_W-1:0] stage_en;

    // Stage i toggles when T is high and every lower stage is already 1; the
    // running carry keeps the chain free of self-referencing vector bits.
    always_comb begin
        logic carry;
        stage_en = '0;
        carry    = T;
        for (int unsigned i = 0; i < CNT_W; i++) begin
            stage_en[i] = carry;
            carry       = carry & stage_q[i];
        end
    end

    for (genvar g = 0; g < CNT_W; g++) begin : g_stage
        t_ff #(
            .RST_VAL (CNT_RST[g])
        ) u_t_ff (
            .clk (clk),
            .rst (rst),
            .en  (stage_en[g]),
            .t   (1'b1),
            .q   (stage_q[g])
        );
    end

    // Count is the concatenation of the stage flops, stage 0 as LSB.
    always_comb begin
        out = stage_q;
    end

endmodule

// File: tb/tb_async_counter3.sv
// Scoreboard bench for async_counter3: stimulus queues expected counts, monitors
// check them mid-cycle and at the falling edge.
module tb_async_counter3;
    import async_counter3_pkg::*;

    typedef struct {
        int               due;
        logic [CNT_W-1:0] exp;
        string            name;
    } sb_item_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_total;
    int   n_pass;

    sb_item_t sb[$];

    async_counter3_if bus ();

    async_counter3 dut (
        .clk (clk),
        .rst (rst),
        .out (bus.out),
        .T   (bus.T)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [CNT_W-1:0] act,
                                  input logic [CNT_W-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: out=%b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Mid-cycle monitor: value just after the edge must already be the expected one.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check({sb[0].name, "@post"}, bus.out, sb[0].exp);
            end
        end
    end

    // Falling-edge monitor: pops every item whose edge has passed.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            sb_item_t it;
            it = sb.pop_front();
            check({it.name, "@neg"}, bus.out, it.exp);
        end
    end

    task automatic step(input logic r, input logic t, input logic [CNT_W-1:0] e,
                        input string nm);
        sb_item_t it;
        @(negedge clk);
        rst   = r;
        bus.T = t;
        it.due  = cyc + 1;
        it.exp  = e;
        it.name = nm;
        sb.push_back(it);
    endtask

    logic [CNT_W-1:0] seq_run [10];
    logic [CNT_W-1:0] seq_wrap [7];
    logic [CNT_W-1:0] model;

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b0;
        bus.T   = 1'b0;
        seq_run  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        seq_wrap = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

        // Reset held two edges with T=1.
        step(1'b1, 1'b1, 3'd0, "rst_edge1");
        step(1'b1, 1'b1, 3'd0, "rst_edge2");

        // Ten counting edges through a wrap.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, seq_run[i], "count");

        // Up to 101, hold three edges, resume.
        step(1'b0, 1'b1, 3'd3, "to5");
        step(1'b0, 1'b1, 3'd4, "to5");
        step(1'b0, 1'b1, 3'd5, "to5");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd5, "hold");
        step(1'b0, 1'b1, 3'd6, "resume");

        // Reset wins over counting, then count restarts from zero.
        step(1'b1, 1'b1, 3'd0, "rst_prio");
        step(1'b0, 1'b1, 3'd1, "after_rst");

        // Run to 111 and wrap to 000.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, seq_wrap[i], "wrap");

        // Hold at zero, reset with T=0.
        step(1'b0, 1'b0, 3'd0, "hold0");
        step(1'b1, 1'b0, 3'd0, "rst_t0");

        // Random T with occasional reset against a reference count.
        model = 3'd0;
        for (int i = 0; i < 200; i++) begin
            logic r;
            logic t;
            r = ($urandom_range(0, 15) == 0);
            t = 1'($urandom_range(0, 1));
            if (r) model = 3'd0;
            else if (t) model = model + 3'd1;
            step(r, t, model, "rand");
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        #1;
        n_total++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: pending=%0d expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
